// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the data-side of the core: default bus widths,
//   the fixed transfer size, and the grant encoding used by the datamem
//   arbiter and by the hazard unit when it reports why the pipeline stalled.
package cpu_pkg;

   localparam int DEFAULT_ADDR_W = 64;
   localparam int DEFAULT_DATA_W = 64;

   // Only full 8-byte transfers exist on this memory.
   localparam int XFER_BYTES = 8;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DBG  = 2'd2
   } grant_t;

endpackage

// File: rtl/mux2_1.sv
// mux2_1
//   Generic two-input multiplexer.
//   Ports:
//     in0, in1 : data inputs (WIDTH bits)
//     sel      : 0 selects in0, 1 selects in1
//     out      : selected data
module mux2_1 #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/starve_counter.sv
// starve_counter
//   Saturating up-counter that tracks how many consecutive cycles the debug
//   port has been refused. It stops at MAX_WAIT and raises sat there.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     clear      : return to zero on the next edge (has priority over inc)
//     inc        : advance by one unless already saturated
//     count      : current count, 0..MAX_WAIT
//     sat        : count has reached MAX_WAIT
module starve_counter #(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_WAIT);

   assign sat = (count == SAT_VAL);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Shares the single-ported data memory between the pipeline MEM stage
//   (default priority) and the debug/loader port. A starvation counter forces
//   the debug port in after MAX_WAIT refused cycles, stalling the pipeline for
//   that one slot.
//
//   Handshakes: a debug transfer happens in a cycle where dbg_valid and
//   dbg_ready are both 1; dbg_valid and all dbg_* request fields must stay
//   stable until then. Reads (and misaligned requests of either kind) are
//   answered by a single-cycle dbg_rvalid pulse on the following cycle.
//   The MEM stage has no handshake: cpu_stall=1 means its access did not
//   happen and must be presented again.
//
//   Ports:
//     cpu_req/we/addr/wdata  : MEM stage access;  cpu_stall back to pipeline
//     dbg_valid/we/addr/wdata: debug request;     dbg_ready accepts it
//     dbg_rvalid/rdata/err   : registered debug response
//     mem_addr/we/wdata      : drive to datamem;  mem_rdata combinational read
module datamem_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   input  logic              dbg_valid,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ready,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W    = $clog2(MAX_WAIT + 1);
   localparam int OFFSET_W = $clog2(XFER_BYTES);

   logic [CNT_W-1:0] starveCnt;
   logic             starveSat;
   logic             forceDbg;
   logic             misaligned;
   grant_t           grant;
   logic             grantDbg;
   logic             grantCpu;
   logic             cntClear;

   assign forceDbg   = dbg_valid && starveSat;
   assign misaligned = (dbg_addr[OFFSET_W-1:0] != '0);

   always_comb begin
      grant = GNT_NONE;
      if (dbg_valid && (!cpu_req || forceDbg)) begin
         grant = GNT_DBG;
      end else if (cpu_req) begin
         grant = GNT_CPU;
      end
   end

   assign grantDbg = (grant == GNT_DBG);
   assign grantCpu = (grant == GNT_CPU);

   // With no grant the address/data muxes still point at the CPU side;
   // only the write enable is gated.
   mux2_1 #(.WIDTH(ADDR_W)) u_addrMux (
      .in0 (cpu_addr),
      .in1 (dbg_addr),
      .sel (grantDbg),
      .out (mem_addr)
   );

   mux2_1 #(.WIDTH(DATA_W)) u_wdataMux (
      .in0 (cpu_wdata),
      .in1 (dbg_wdata),
      .sel (grantDbg),
      .out (mem_wdata)
   );

   assign mem_we    = (grantCpu && cpu_we) || (grantDbg && dbg_we && !misaligned);
   assign cpu_stall = cpu_req && !grantCpu;
   assign dbg_ready = grantDbg;

   // Counter restarts whenever the debug port is served or not asking.
   assign cntClear = grantDbg || !dbg_valid;

   starve_counter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_starveCounter (
      .clk   (clk),
      .reset (reset),
      .clear (cntClear),
      .inc   (!cntClear),
      .count (starveCnt),
      .sat   (starveSat)
   );

   // Response channel. An error response always carries zero data; aligned
   // writes leave the last read data in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         dbg_rvalid <= 1'b0;
         dbg_err    <= 1'b0;
         dbg_rdata  <= '0;
      end else if (grantDbg) begin
         dbg_rvalid <= !dbg_we || misaligned;
         dbg_err    <= misaligned;
         if (misaligned) begin
            dbg_rdata <= '0;
         end else if (!dbg_we) begin
            dbg_rdata <= mem_rdata;
         end
      end else begin
         dbg_rvalid <= 1'b0;
         dbg_err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;

   localparam int W        = 64;
   localparam int MAX_WAIT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic         cpu_req, cpu_we, cpu_stall;
   logic [W-1:0] cpu_addr, cpu_wdata;
   logic         dbg_valid, dbg_we, dbg_ready, dbg_rvalid, dbg_err;
   logic [W-1:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         mem_we;

   datamem_arbiter #(.ADDR_W(W), .DATA_W(W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_stall  (cpu_stall),
      .dbg_valid  (dbg_valid),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_ready  (dbg_ready),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .dbg_err    (dbg_err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // ---------------- data memory model (combinational read) ----------------
   logic [W-1:0] mem [128];
   initial for (int i = 0; i < 128; i++) mem[i] = '0;
   always @(posedge clk) if (mem_we) mem[mem_addr[9:3]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[9:3]];

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic         cpu_req, cpu_we;
      logic [W-1:0] cpu_addr, cpu_wdata;
      logic         dbg_valid, dbg_we;
      logic [W-1:0] dbg_addr, dbg_wdata;
      logic         e_stall, e_ready, e_mem_we;
      logic [W-1:0] e_mem_addr;
      logic         e_rvalid, e_err;
      logic [W-1:0] e_rdata;
      logic         chk_mrd;
      logic [W-1:0] e_mrd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic cr, input logic cw, input logic [W-1:0] ca, input logic [W-1:0] cd,
      input logic dv, input logic dw, input logic [W-1:0] da, input logic [W-1:0] dd,
      input logic es, input logic er, input logic ew, input logic [W-1:0] ea,
      input logic erv, input logic ee, input logic [W-1:0] erd,
      input logic cm, input logic [W-1:0] em);
      vec_t v;
      v.cpu_req = cr; v.cpu_we = cw; v.cpu_addr = ca; v.cpu_wdata = cd;
      v.dbg_valid = dv; v.dbg_we = dw; v.dbg_addr = da; v.dbg_wdata = dd;
      v.e_stall = es; v.e_ready = er; v.e_mem_we = ew; v.e_mem_addr = ea;
      v.e_rvalid = erv; v.e_err = ee; v.e_rdata = erd;
      v.chk_mrd = cm; v.e_mrd = em;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic drive_vec(input vec_t v);
      cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      dbg_valid = v.dbg_valid; dbg_we = v.dbg_we; dbg_addr = v.dbg_addr; dbg_wdata = v.dbg_wdata;
   endtask

   task automatic check_vec(input int idx, input vec_t v);
      string p;
      p = $sformatf("vec%0d", idx);
      chk({p, ".cpu_stall"},  W'(cpu_stall),  W'(v.e_stall));
      chk({p, ".dbg_ready"},  W'(dbg_ready),  W'(v.e_ready));
      chk({p, ".mem_we"},     W'(mem_we),     W'(v.e_mem_we));
      chk({p, ".mem_addr"},   mem_addr,       v.e_mem_addr);
      chk({p, ".dbg_rvalid"}, W'(dbg_rvalid), W'(v.e_rvalid));
      chk({p, ".dbg_err"},    W'(dbg_err),    W'(v.e_err));
      chk({p, ".dbg_rdata"},  dbg_rdata,      v.e_rdata);
      if (v.chk_mrd) chk({p, ".mem_rdata"}, mem_rdata, v.e_mrd);
   endtask

   // cpu_req held high with a debug read of 0x80 pending: refused for
   // MAX_WAIT cycles, granted on the next, response one cycle later.
   task automatic run_contention(input string tag);
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h40;
      dbg_valid = 1; dbg_we = 0; dbg_addr = 64'h80;
      for (int c = 0; c <= MAX_WAIT; c++) begin
         #1;
         chk($sformatf("%s.c%0d.cnt", tag, c),   W'(dut.starveCnt), W'(c));
         chk($sformatf("%s.c%0d.ready", tag, c), W'(dbg_ready),     W'(c == MAX_WAIT));
         chk($sformatf("%s.c%0d.stall", tag, c), W'(cpu_stall),     W'(c == MAX_WAIT));
         chk($sformatf("%s.c%0d.addr", tag, c),  mem_addr,          (c == MAX_WAIT) ? 64'h80 : 64'h40);
         @(negedge clk);
      end
      dbg_valid = 0;
      #1;
      chk({tag, ".rvalid"}, W'(dbg_rvalid), W'(1));
      chk({tag, ".rdata"},  dbg_rdata,      64'h1234);
      chk({tag, ".stall"},  W'(cpu_stall),  W'(0));
      chk({tag, ".cnt0"},   W'(dut.starveCnt), W'(0));
      @(negedge clk);
      drive_idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1;
      drive_idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset.rvalid", W'(dbg_rvalid), W'(0));
      chk("reset.rdata",  dbg_rdata,      W'(0));
      chk("reset.err",    W'(dbg_err),    W'(0));
      chk("reset.cnt",    W'(dut.starveCnt), W'(0));
      chk("reset.mem_we", W'(mem_we),     W'(0));
      chk("reset.ready",  W'(dbg_ready),  W'(0));

      //           cr cw ca      cd             dv dw da     dd        es er ew ea     rv er rdata         cm mrd
      vecs.push_back(mk(1, 1, 64'h40, 64'hDEADBEEF, 0, 0, 64'h0,  64'h0,    0, 0, 1, 64'h40, 0, 0, 64'h0,       0, 64'h0));
      vecs.push_back(mk(1, 0, 64'h40, 64'h0,        0, 0, 64'h0,  64'h0,    0, 0, 0, 64'h40, 0, 0, 64'h0,       1, 64'hDEADBEEF));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 1, 64'h80, 64'h1234, 0, 1, 1, 64'h80, 0, 0, 64'h0,       0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 0, 64'h80, 64'h0,    0, 1, 0, 64'h80, 0, 0, 64'h0,       0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        0, 0, 64'h0,  64'h0,    0, 0, 0, 64'h0,  1, 0, 64'h1234,    0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 1, 64'h83, 64'hFFFF, 0, 1, 0, 64'h83, 0, 0, 64'h1234,    0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 0, 64'h80, 64'h0,    0, 1, 0, 64'h80, 1, 1, 64'h0,       1, 64'h1234));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        0, 0, 64'h0,  64'h0,    0, 0, 0, 64'h0,  1, 0, 64'h1234,    0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        0, 0, 64'h0,  64'h0,    0, 0, 0, 64'h0,  0, 0, 64'h1234,    0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 0, 64'h40, 64'h0,    0, 1, 0, 64'h40, 0, 0, 64'h1234,    0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        1, 0, 64'h80, 64'h0,    0, 1, 0, 64'h80, 1, 0, 64'hDEADBEEF, 0, 64'h0));
      vecs.push_back(mk(0, 0, 64'h0,  64'h0,        0, 0, 64'h0,  64'h0,    0, 0, 0, 64'h0,  1, 0, 64'h1234,    0, 64'h0));

      reset = 0;
      foreach (vecs[i]) begin
         drive_vec(vecs[i]);
         #1;
         check_vec(i, vecs[i]);
         @(negedge clk);
      end
      drive_idle();
      @(negedge clk);

      // Contention with saturating counter.
      run_contention("contend");

      // Counter clear: two refused cycles, then cpu_req drops.
      cpu_req = 1; cpu_addr = 64'h40; dbg_valid = 1; dbg_we = 0; dbg_addr = 64'h80;
      #1; chk("clr.c0.ready", W'(dbg_ready), W'(0)); chk("clr.c0.cnt", W'(dut.starveCnt), W'(0));
      @(negedge clk);
      #1; chk("clr.c1.ready", W'(dbg_ready), W'(0)); chk("clr.c1.cnt", W'(dut.starveCnt), W'(1));
      @(negedge clk);
      cpu_req = 0;
      #1; chk("clr.c2.ready", W'(dbg_ready), W'(1)); chk("clr.c2.cnt", W'(dut.starveCnt), W'(2));
      @(negedge clk);
      dbg_valid = 0;
      #1; chk("clr.c3.cnt", W'(dut.starveCnt), W'(0)); chk("clr.c3.rvalid", W'(dbg_rvalid), W'(1));
      @(negedge clk);
      run_contention("clr.again");

      // Reset on the edge that ends a debug read grant.
      cpu_req = 1; cpu_addr = 64'h40; dbg_valid = 1; dbg_we = 0; dbg_addr = 64'h80;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 0; reset = 1;
      #1; chk("rst.ready", W'(dbg_ready), W'(1));
      @(negedge clk);
      reset = 0; dbg_valid = 0;
      #1;
      chk("rst.rvalid", W'(dbg_rvalid), W'(0));
      chk("rst.cnt",    W'(dut.starveCnt), W'(0));
      @(negedge clk);
      dbg_valid = 1; dbg_we = 0; dbg_addr = 64'h80;
      #1; chk("rst.read.ready", W'(dbg_ready), W'(1));
      @(negedge clk);
      dbg_valid = 0;
      #1;
      chk("rst.read.rvalid", W'(dbg_rvalid), W'(1));
      chk("rst.read.rdata",  dbg_rdata,      64'h1234);
      chk("rst.read.err",    W'(dbg_err),    W'(0));
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
